backend_ctrl: RTL and testbench

//  Single-clock backend command router between the host SPI link and up to four detector modules.
//  - Host writes 32-bit command words over SPI; each valid command is serialised to the addressed module's control line.
//  - Module response words arrive on per-module serial lines, are queued in a FIFO, and are returned on later SPI frames.
//  - Sits between the Ethernet-bridge SPI port and the module link PHYs.

---
 rtl/backend_ctrl_if.sv | 22 ++
 rtl/backend_ctrl.sv | 168 ++++++++++++++++
 tb/tb_backend_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/backend_ctrl_if.sv
// rtl/backend_ctrl_if.sv - host SPI link and module link signals of the backend command router
interface backend_ctrl_if #(
    parameter int NMOD = 4
);
    logic            spi_cs_n;
    logic            spi_sck;
    logic            spi_mosi;
    logic            spi_miso;
    logic [NMOD-1:0] m_ctrl;
    logic [NMOD-1:0] m_resp;
    logic            fifo_ovf;

    modport master (
        output spi_cs_n, spi_sck, spi_mosi, m_resp,
        input  spi_miso, m_ctrl, fifo_ovf
    );

    modport slave (
        input  spi_cs_n, spi_sck, spi_mosi, m_resp,
        output spi_miso, m_ctrl, fifo_ovf
    );
endinterface

// File: rtl/backend_ctrl.sv
// rtl/backend_ctrl.sv - SPI command router to NMOD module links with a shared response FIFO
module backend_ctrl #(
    parameter int NMOD       = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    backend_ctrl_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    // [1] is the synchronised level, [2] the previous one for edge detection
    logic [2:0] cs_q;
    logic [2:0] sck_q;
    logic [1:0] mosi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q   <= 3'b111;
            sck_q  <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            cs_q   <= {cs_q[1:0], bus.spi_cs_n};
            sck_q  <= {sck_q[1:0], bus.spi_sck};
            mosi_q <= {mosi_q[0], bus.spi_mosi};
        end
    end

    logic cs_low, cs_fall, cs_rise, sck_rise, sck_fall;
    assign cs_low   = ~cs_q[1];
    assign cs_fall  =  cs_q[2] & ~cs_q[1];
    assign cs_rise  = ~cs_q[2] &  cs_q[1];
    assign sck_rise = ~sck_q[2] &  sck_q[1];
    assign sck_fall =  sck_q[2] & ~sck_q[1];

    logic [31:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, push, pop;
    logic [31:0] push_word, fifo_head;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];
    assign pop        = cs_fall & ~fifo_empty;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[AW-1:0]] <= push_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    logic [31:0] tx_sh, rx_sh;
    logic [5:0]  bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh   <= '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
        end else if (cs_fall) begin
            tx_sh   <= fifo_empty ? 32'h0 : fifo_head;
            bit_cnt <= '0;
        end else if (cs_low) begin
            if (sck_rise) begin
                rx_sh <= {rx_sh[30:0], mosi_q[1]};
                if (bit_cnt != 6'd33)
                    bit_cnt <= bit_cnt + 6'd1;
            end
            // the leading falling edge precedes the host's first sample, so bit 31 must stay put
            if (sck_fall && bit_cnt != 6'd0)
                tx_sh <= {tx_sh[30:0], 1'b0};
        end
    end

    assign bus.spi_miso = tx_sh[31];

    logic frame_ok, cmd_ok;
    assign frame_ok = cs_rise && (bit_cnt == 6'd32);
    assign cmd_ok   = frame_ok && (rx_sh != 32'h0) && (rx_sh[31:28] == 4'hF)
                      && (int'(rx_sh[27:24]) < NMOD);

    // start bit in [32]; shifting in zeros returns the line low after the last data bit
    logic [32:0] ser_sh [NMOD];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < NMOD; m++)
                ser_sh[m] <= '0;
        end else begin
            for (int m = 0; m < NMOD; m++) begin
                if (cmd_ok && rx_sh[27:24] == 4'(m))
                    ser_sh[m] <= {1'b1, rx_sh};
                else
                    ser_sh[m] <= {ser_sh[m][31:0], 1'b0};
            end
        end
    end

    always_comb begin
        bus.m_ctrl = '0;
        for (int m = 0; m < NMOD; m++)
            bus.m_ctrl[m] = ser_sh[m][32];
    end

    logic [5:0]      rcv_cnt   [NMOD];
    logic [30:0]     rcv_sh    [NMOD];
    logic [31:0]     pend_word [NMOD];
    logic [NMOD-1:0] rcv_drop, pend, grant;
    logic            found;

    always_comb begin
        grant     = '0;
        push_word = '0;
        found     = 1'b0;
        for (int m = 0; m < NMOD; m++) begin
            if (!fifo_full && pend[m] && !found) begin
                grant[m]  = 1'b1;
                push_word = pend_word[m];
                found     = 1'b1;
            end
        end
    end

    assign push = |grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < NMOD; m++) begin
                rcv_cnt[m]   <= '0;
                rcv_sh[m]    <= '0;
                pend_word[m] <= '0;
            end
            rcv_drop     <= '0;
            pend         <= '0;
            bus.fifo_ovf <= 1'b0;
        end else begin
            for (int m = 0; m < NMOD; m++) begin
                if (grant[m])
                    pend[m] <= 1'b0;
                if (rcv_cnt[m] == 6'd0) begin
                    if (bus.m_resp[m]) begin
                        rcv_cnt[m]  <= 6'd32;
                        // a word still stuck behind a full FIFO wins over the new frame
                        rcv_drop[m] <= pend[m] & ~grant[m];
                        if (pend[m] && !grant[m])
                            bus.fifo_ovf <= 1'b1;
                    end
                end else begin
                    rcv_sh[m]  <= {rcv_sh[m][29:0], bus.m_resp[m]};
                    rcv_cnt[m] <= rcv_cnt[m] - 6'd1;
                    if (rcv_cnt[m] == 6'd1 && !rcv_drop[m]) begin
                        pend[m]      <= 1'b1;
                        pend_word[m] <= {rcv_sh[m], bus.m_resp[m]};
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_backend_ctrl.sv
// tb/tb_backend_ctrl.sv - randomized self-checking bench for backend_ctrl against a queue model
module tb_backend_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    backend_ctrl_if #(.NMOD(4)) bif();
    backend_ctrl #(.NMOD(4), .FIFO_DEPTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

    int n_checks = 0;
    int n_errors = 0;

    // Model: response store is a 16-word queue plus one held word per module
    logic [31:0] exp_fifo [$];
    logic [3:0]  pend_v;
    logic [31:0] pend_w [4];
    logic        ovf_m;
    logic [35:0] obs_cmd [$];
    int          mon_cnt [4];
    logic [31:0] mon_sh [4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int m = 0; m < 4; m++) mon_cnt[m] <= 0;
        end else begin
            for (int m = 0; m < 4; m++) begin
                if (mon_cnt[m] == 0) begin
                    if (bif.m_ctrl[m]) mon_cnt[m] <= 32;
                end else begin
                    mon_sh[m]  <= {mon_sh[m][30:0], bif.m_ctrl[m]};
                    mon_cnt[m] <= mon_cnt[m] - 1;
                    if (mon_cnt[m] == 1)
                        obs_cmd.push_back({4'(m), mon_sh[m][30:0], bif.m_ctrl[m]});
                end
            end
        end
    end

    function automatic void model_drain();
        bit moved;
        do begin
            moved = 1'b0;
            for (int m = 0; m < 4; m++) begin
                if (!moved && pend_v[m] && exp_fifo.size() < 16) begin
                    exp_fifo.push_back(pend_w[m]);
                    pend_v[m] = 1'b0;
                    moved = 1'b1;
                end
            end
        end while (moved);
    endfunction

    function automatic void model_arrive(input int m, input logic [31:0] w);
        if (pend_v[m]) begin
            ovf_m = 1'b1;
        end else if (exp_fifo.size() < 16) begin
            exp_fifo.push_back(w);
        end else begin
            pend_v[m] = 1'b1;
            pend_w[m] = w;
        end
    endfunction

    function automatic logic [31:0] model_pop();
        logic [31:0] w;
        w = (exp_fifo.size() > 0) ? exp_fifo.pop_front() : 32'h0;
        model_drain();
        return w;
    endfunction

    function automatic void model_reset();
        exp_fifo.delete();
        pend_v = '0;
        ovf_m  = 1'b0;
    endfunction

    task automatic send_resp(input logic [3:0] mask, input logic [3:0][31:0] ws);
        model_drain();
        for (int m = 0; m < 4; m++)
            if (mask[m]) model_arrive(m, ws[m]);
        @(negedge clk);
        bif.m_resp = mask;
        for (int b = 31; b >= 0; b--) begin
            @(negedge clk);
            for (int m = 0; m < 4; m++)
                bif.m_resp[m] = mask[m] & ws[m][b];
        end
        @(negedge clk);
        bif.m_resp = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic spi_frame(input string tag, input logic [31:0] wout, input int nbits);
        logic [31:0] win;
        logic [31:0] exp_w;
        logic        exp_cmd;
        win = '0;
        exp_w = model_pop();
        @(negedge clk);
        bif.spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bif.spi_sck  = 1'b0;
            bif.spi_mosi = (i < 32) ? wout[31-i] : 1'b0;
            repeat (8) @(negedge clk);
            bif.spi_sck = 1'b1;
            if (i < 32) win[31-i] = bif.spi_miso;
            repeat (8) @(negedge clk);
        end
        bif.spi_cs_n = 1'b1;
        bif.spi_mosi = 1'b0;
        repeat (50) @(negedge clk);
        if (nbits == 32) chk({tag, "_miso"}, win, exp_w);
        exp_cmd = (nbits == 32) && (wout[31:28] == 4'hF) && (wout[27:24] < 4'd4);
        chk({tag, "_ncmd"}, obs_cmd.size(), exp_cmd);
        if (exp_cmd && obs_cmd.size() == 1)
            chk({tag, "_cmd"}, obs_cmd[0], {wout[27:24], wout});
        obs_cmd.delete();
        chk({tag, "_ovf"}, bif.fifo_ovf, ovf_m);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0][31:0] ws;
        logic [31:0]      w;
        int               nb;

        bif.spi_cs_n = 1'b1;
        bif.spi_sck  = 1'b1;
        bif.spi_mosi = 1'b0;
        bif.m_resp   = '0;
        model_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_miso", bif.spi_miso, 1'b0);
        chk("rst_mctrl", bif.m_ctrl, 4'b0000);
        chk("rst_ovf", bif.fifo_ovf, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        spi_frame("t1_read", 32'h0, 32);
        spi_frame("t2_cmd", 32'hF030_0000, 32);

        ws = '0;
        ws[0] = 32'hF130_ABCD;
        send_resp(4'b0001, ws);
        spi_frame("t3_read", 32'h0, 32);
        spi_frame("t3_empty", 32'h0, 32);

        spi_frame("t4_badtag", 32'h7030_0000, 32);
        spi_frame("t4_badmod", 32'hF530_0000, 32);
        spi_frame("t4_short", 32'hF064_04F1, 20);

        ws = '0;
        ws[0] = 32'h0000_0001;
        ws[1] = 32'h1111_1111;
        send_resp(4'b0011, ws);
        spi_frame("t5_first", 32'h0, 32);
        spi_frame("t5_second", 32'h0, 32);

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    case ($urandom_range(0, 3))
                        0: w = {4'hF, 4'($urandom_range(0, 3)), 24'($urandom)};
                        1: w = {4'hF, 4'($urandom_range(4, 15)), 24'($urandom)};
                        2: w = $urandom;
                        default: w = 32'h0;
                    endcase
                    nb = ($urandom_range(0, 9) < 7) ? 32 : int'($urandom_range(20, 36));
                    spi_frame("rnd_cmd", w, nb);
                end
                1: begin
                    for (int m = 0; m < 4; m++) ws[m] = $urandom;
                    if ($urandom_range(0, 3) == 0)
                        send_resp(4'($urandom_range(1, 15)), ws);
                    else
                        send_resp(4'(1 << $urandom_range(0, 3)), ws);
                end
                default: spi_frame("rnd_read", 32'h0, 32);
            endcase
        end

        for (int k = 0; k < 40 && (exp_fifo.size() > 0 || pend_v != 0); k++)
            spi_frame("drain", 32'h0, 32);

        for (int k = 0; k < 18; k++) begin
            ws = '0;
            ws[2] = {8'hA5, 8'(k), 16'($urandom)};
            send_resp(4'b0100, ws);
        end
        chk("t6_ovf", bif.fifo_ovf, 1'b1);
        for (int k = 0; k < 17; k++)
            spi_frame("t6_read", 32'h0, 32);
        spi_frame("t6_empty", 32'h0, 32);

        @(negedge clk);
        bif.m_resp[3] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            bif.m_resp[3] = 1'($urandom);
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_miso", bif.spi_miso, 1'b0);
        chk("mid_rst_mctrl", bif.m_ctrl, 4'b0000);
        chk("mid_rst_ovf", bif.fifo_ovf, 1'b0);
        model_reset();
        bif.m_resp = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        spi_frame("post_rst_read", 32'h0, 32);
        ws = '0;
        ws[3] = 32'h5A5A_C3C3;
        send_resp(4'b1000, ws);
        spi_frame("post_rst_resp", 32'h0, 32);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
